// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one operation at a time through an external ripple ALU.
// Arithmetic and logic operations take a single EXEC cycle. Shifts are done
// locally, one bit per cycle.
//
// Ports:
//   Clock, Reset          sole clock; synchronous active-high reset
//   InValid/InReady       request handshake; Op, OperandA, OperandB are captured on accept
//   AluA, AluB            registered operands driven to the downstream ALU
//   AluCarryIn, AluOr, AluFloodCarry, AluInvertA, AluInvertB
//                         ALU control lines, decoded from the registered Op
//   AluOutC, AluCarryOut  ALU result and carry out
//   OutValid/OutReady     result handshake; Result is held stable while OutValid is high
module alu_sequencer #(
  parameter int unsigned width = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       Op,
  input  logic [width-1:0] OperandA,
  input  logic [width-1:0] OperandB,
  output logic [width-1:0] AluA,
  output logic [width-1:0] AluB,
  output logic             AluCarryIn,
  output logic             AluOr,
  output logic             AluFloodCarry,
  output logic             AluInvertA,
  output logic             AluInvertB,
  input  logic [width-1:0] AluOutC,
  input  logic             AluCarryOut,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [width-1:0] Result
);

  localparam int unsigned CntW = $clog2(width);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StExec  = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpSlt  = 4'd5;
  localparam logic [3:0] OpSltu = 4'd6;
  localparam logic [3:0] OpSll  = 4'd7;
  localparam logic [3:0] OpSrl  = 4'd8;
  localparam logic [3:0] OpSra  = 4'd9;

  logic [1:0]       stateQ, stateD;
  logic [3:0]       opQ;
  logic [width-1:0] aQ, bQ;
  logic [width-1:0] shiftQ, shiftNext;
  logic [width-1:0] resultQ, execResult;
  logic [CntW-1:0]  countQ;
  logic             isShiftOp;
  logic [4:0]       ctrl;

  assign InReady  = (stateQ == StIdle) && !Reset;
  assign OutValid = (stateQ == StDone);
  assign Result   = resultQ;
  assign AluA     = aQ;
  assign AluB     = bQ;

  assign isShiftOp = (Op == OpSll) || (Op == OpSrl) || (Op == OpSra);

  // Control word order: {InvertA, InvertB, CarryIn, Or, FloodCarry}.
  always_comb begin
    ctrl = 5'b00000;
    case (opQ)
      OpSub, OpSlt, OpSltu: ctrl = 5'b01100;
      OpAnd:                ctrl = 5'b11011;
      OpOr:                 ctrl = 5'b00010;
      OpXor:                ctrl = 5'b01001;
      default:              ctrl = 5'b00000;
    endcase
  end

  assign AluInvertA    = ctrl[4];
  assign AluInvertB    = ctrl[3];
  assign AluCarryIn    = ctrl[2];
  assign AluOr         = ctrl[1];
  assign AluFloodCarry = ctrl[0];

  always_comb begin
    execResult = '0;
    case (opQ)
      OpAdd, OpSub, OpAnd, OpOr, OpXor: execResult = AluOutC;
      // A - B borrows exactly when the carry out is clear.
      OpSltu: execResult = {{(width-1){1'b0}}, ~AluCarryOut};
      // Differing signs decide directly; otherwise the subtraction sign is exact.
      OpSlt: execResult = {{(width-1){1'b0}},
                           (aQ[width-1] != bQ[width-1]) ? aQ[width-1] : AluOutC[width-1]};
      default: execResult = '0;
    endcase
  end

  always_comb begin
    shiftNext = shiftQ;
    case (opQ)
      OpSll:   shiftNext = {shiftQ[width-2:0], 1'b0};
      OpSrl:   shiftNext = {1'b0, shiftQ[width-1:1]};
      OpSra:   shiftNext = {shiftQ[width-1], shiftQ[width-1:1]};
      default: shiftNext = shiftQ;
    endcase
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle:  if (InValid) stateD = isShiftOp ? StShift : StExec;
      StExec:  stateD = StDone;
      StShift: if (countQ == '0) stateD = StDone;
      StDone:  if (OutReady) stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateQ  <= StIdle;
      opQ     <= '0;
      aQ      <= '0;
      bQ      <= '0;
      shiftQ  <= '0;
      countQ  <= '0;
      resultQ <= '0;
    end else begin
      stateQ <= stateD;
      case (stateQ)
        StIdle: begin
          if (InValid) begin
            opQ    <= Op;
            aQ     <= OperandA;
            bQ     <= OperandB;
            shiftQ <= OperandA;
            countQ <= OperandB[CntW-1:0];
          end
        end
        StExec: resultQ <= execResult;
        StShift: begin
          if (countQ != '0) begin
            shiftQ <= shiftNext;
            countQ <= countQ - {{(CntW-1){1'b0}}, 1'b1};
          end else begin
            resultQ <= shiftQ;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  localparam int unsigned W = 32;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         InValid;
  logic         InReady;
  logic [3:0]   Op;
  logic [W-1:0] OperandA, OperandB;
  logic [W-1:0] AluA, AluB;
  logic         AluCarryIn, AluOr, AluFloodCarry, AluInvertA, AluInvertB;
  logic [W-1:0] AluOutC;
  logic         AluCarryOut;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] Result;

  int checks = 0;
  int errors = 0;
  logic lastCarry;

  alu_sequencer #(.width(W)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB), .AluA(AluA), .AluB(AluB),
    .AluCarryIn(AluCarryIn), .AluOr(AluOr), .AluFloodCarry(AluFloodCarry),
    .AluInvertA(AluInvertA), .AluInvertB(AluInvertB), .AluOutC(AluOutC),
    .AluCarryOut(AluCarryOut), .OutValid(OutValid), .OutReady(OutReady), .Result(Result)
  );

  always #5 Clock = ~Clock;

  // Downstream ripple ALU: optional operand inversion, then add, OR, or
  // a flooded carry that inverts the XOR/OR term.
  logic [W-1:0] aluX, aluY;
  logic [W:0]   aluSum;
  always_comb begin
    aluX        = AluInvertA ? ~AluA : AluA;
    aluY        = AluInvertB ? ~AluB : AluB;
    aluSum      = '0;
    AluOutC     = '0;
    AluCarryOut = 1'b0;
    if (AluFloodCarry) begin
      AluOutC = ~(AluOr ? (aluX | aluY) : (aluX ^ aluY));
    end else if (AluOr) begin
      AluOutC = aluX | aluY;
    end else begin
      aluSum      = {1'b0, aluX} + {1'b0, aluY} + {{W{1'b0}}, AluCarryIn};
      AluOutC     = aluSum[W-1:0];
      AluCarryOut = aluSum[W];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] refResult(input logic [3:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    int unsigned amt;
    amt = b % W;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd6: return (a < b) ? 1 : 0;
      4'd7: return a << amt;
      4'd8: return a >> amt;
      4'd9: return $signed(a) >>> amt;
      default: return '0;
    endcase
  endfunction

  function automatic int refLatency(input logic [3:0] op, input logic [W-1:0] b);
    if (op >= 4'd7 && op <= 4'd9) return 2 + int'(b % W);
    return 2;
  endfunction

  // Starts just after a falling edge with the DUT idle; returns idle again.
  task automatic runOp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold);
    int lat;
    logic [W-1:0] expRes;
    expRes   = refResult(op, a, b);
    InValid  = 1'b1;
    Op       = op;
    OperandA = a;
    OperandB = b;
    #1;
    check("inReadyAccept", InReady, 1);
    @(negedge Clock);
    InValid  = 1'b0;
    Op       = 4'($urandom);
    OperandA = $urandom;
    OperandB = $urandom;
    #1;
    check("aluA", AluA, a);
    check("aluB", AluB, b);
    lastCarry = AluCarryOut;
    lat = 1;
    while (!OutValid && lat < 100) begin
      @(negedge Clock);
      #1;
      lat++;
    end
    check($sformatf("latency op%0d", op), lat, refLatency(op, b));
    check($sformatf("result op%0d", op), Result, expRes);
    for (int i = 0; i < hold; i++) begin
      InValid  = 1'b1;
      Op       = 4'($urandom);
      OperandA = $urandom;
      OperandB = $urandom;
      @(negedge Clock);
      #1;
      check("holdValid", OutValid, 1);
      check("holdResult", Result, expRes);
      check("holdInReady", InReady, 0);
    end
    InValid  = 1'b0;
    OutReady = 1'b1;
    @(negedge Clock);
    OutReady = 1'b0;
    #1;
    check("idleInReady", InReady, 1);
    check("idleOutValid", OutValid, 0);
  endtask

  initial begin
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;
    Reset    = 1'b1;
    InValid  = 1'b0;
    Op       = '0;
    OperandA = '0;
    OperandB = '0;
    OutReady = 1'b0;
    repeat (3) @(negedge Clock);
    #1;
    check("rstInReady", InReady, 0);
    check("rstOutValid", OutValid, 0);
    check("rstResult", Result, 0);
    check("rstAluA", AluA, 0);
    Reset = 1'b0;
    #1;
    check("postRstInReady", InReady, 1);

    runOp(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    check("addCarry", lastCarry, 1);
    runOp(4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    runOp(4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    runOp(4'd1, 32'd5, 32'd7, 0);
    runOp(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    runOp(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    runOp(4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 5);
    runOp(4'd9, 32'h8000_0000, 32'd31, 0);
    runOp(4'd7, 32'h0000_1234, 32'h0000_0020, 0);
    runOp(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 1);
    runOp(4'd4, 32'hDEAD_BEEF, 32'h1111_1111, 0);

    // Reset mid-shift: SRL by 20 accepted at t, reset during cycle t+8.
    InValid  = 1'b1;
    Op       = 4'd8;
    OperandA = 32'hCAFE_F00D;
    OperandB = 32'd20;
    @(negedge Clock);
    InValid = 1'b0;
    repeat (7) @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("midRstInReady", InReady, 0);
    check("midRstOutValid", OutValid, 0);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("afterRstOutValid", OutValid, 0);
    check("afterRstResult", Result, 0);
    check("afterRstAluA", AluA, 0);
    check("afterRstAluB", AluB, 0);
    check("afterRstInReady", InReady, 1);
    runOp(4'd0, 32'd100, 32'd23, 0);

    for (int n = 0; n < 200; n++) begin
      rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      case ($urandom_range(0, 3))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = 32'($urandom_range(0, 40));
        default: rb = $urandom;
      endcase
      runOp(rop, ra, rb, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter width, default 32, datapath width in bits; a power of two, at least 4.
REQ-002 SHALL have port Clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port InValid  in  1  request valid.
REQ-005 SHALL have port InReady  out  1  request accepted when InValid and InReady are both high.
REQ-006 SHALL have port Op  in  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA; 10-15 illegal.
REQ-007 SHALL have ports OperandA, OperandB  in  width  source operands.
REQ-008 SHALL have ports AluA, AluB  out  width  operands driven to the downstream ripple ALU.
REQ-009 SHALL have ports AluCarryIn, AluOr, AluFloodCarry, AluInvertA, AluInvertB  out  1 each  ALU control lines.
REQ-010 SHALL have port AluOutC  in  width  ALU result.
REQ-011 SHALL have port AluCarryOut  in  1  ALU carry out.
REQ-012 SHALL have port OutValid  out  1  result valid.
REQ-013 SHALL have port OutReady  in  1  result consumed when OutValid and OutReady are both high.
REQ-014 SHALL have port Result  out  width  registered result.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, SHIFT, DONE; InReady = (state==IDLE) and Reset low.
REQ-016 On accept in IDLE: register Op, OperandA, OperandB; shift count = OperandB[log2(width)-1:0]; next state is EXEC for ops 0-6 and illegal ops, SHIFT for ops 7-9.
REQ-017 AluA/AluB SHALL always equal the registered operands; control lines are decoded from the registered Op as {InvertA, InvertB, CarryIn, Or, FloodCarry}: ADD 00000; SUB, SLT, SLTU 01100; AND 11011; OR 00010; XOR 01001; all other ops 00000.
REQ-018 EXEC (one cycle) SHALL capture into Result: AluOutC for ADD/SUB/AND/OR/XOR; zero-extended (AluCarryOut==0) for SLTU; for SLT, A[msb] when A[msb]!=B[msb], else AluOutC[msb], zero-extended; zero for illegal ops. Next state: DONE.
REQ-019 SHIFT SHALL preload the shift register with the registered OperandA; each cycle with count!=0: shift one bit (SLL left zero-fill, SRL right zero-fill, SRA right sign-fill) and decrement count; when count==0: copy the shift register to Result and go to DONE.
REQ-020 Latency from the accept cycle t: OutValid high from cycle t+2 for ops 0-6 and illegal ops; from t+2+N for shifts with amount N; maximum t+1+width.
REQ-021 DONE SHALL hold OutValid=1 and Result stable until OutReady is high, then go to IDLE; OutValid is low in every state other than DONE.
REQ-022 Bits of OperandB above log2(width)-1 SHALL be ignored for shifts; shift amount 0 returns OperandA unchanged.
REQ-023 InValid while not in IDLE SHALL be ignored; the request is not captured and the upstream holds it.
REQ-024 Input changes after accept SHALL have no effect on the operation in flight.

Reset
REQ-025 Reset high at a clock edge SHALL force IDLE, OutValid=0, Result=0, shift count 0, and registered operands and Op to 0 (ALU outputs all zero), from any state including mid-SHIFT or DONE; the in-flight operation is discarded.
REQ-026 InReady SHALL be 0 while Reset is high and 1 in the first cycle after Reset falls.

Verification
REQ-027 ADD A=0xFFFFFFFF, B=0x00000001 accepted at t -> Result 0x00000000, OutValid high at t+2, AluCarryOut observed 1 during EXEC.
REQ-028 SLT A=0xFFFFFFFF, B=0x00000001 -> Result 1; SLTU with the same operands -> Result 0; SUB 5-7 -> 0xFFFFFFFE.
REQ-029 XOR 0xF0F0F0F0 and 0xFF00FF00 -> 0x0FF00FF0; AND -> 0xF000F000; OR -> 0xFFF0FFF0.
REQ-030 SRA A=0x80000000, B=31 accepted at t -> 0xFFFFFFFF at t+33; SLL A=0x1234, B=0x20 (amount 0) -> 0x1234 at t+2.
REQ-031 Hold OutReady low for 5 cycles in DONE -> OutValid and Result stable, InReady 0, new InValid ignored; OutReady high -> InReady 1 next cycle.
REQ-032 Reset asserted for one cycle mid-SRL (amount 20, at cycle t+8) -> OutValid 0, Result 0 next cycle; InReady 1 the cycle after Reset falls; a subsequent ADD completes normally.
